// File: rtl/mbu_loader.sv
`default_nettype none
// ============================================================================
//  Module      : mbu_loader
//  Description : Bus initiator that programs the Memory Bank Unit through the
//                CU write/read-unit interface. Holds an 8-entry shadow table;
//                on start it acquires the IBus, optionally writes CTX, writes
//                MB0..MB7 and optionally reads them back for comparison.
//  Revision    : 1.0 - initial release
// ============================================================================
module mbu_loader #(
    parameter bit         VERIFY    = 1'b1,
    parameter bit         WRITE_CTX = 1'b1,
    parameter logic [4:0] WADDR_MBN = 5'b11011,
    parameter logic [4:0] WADDR_CTX = 5'b11110,
    parameter logic [4:0] RADDR_MBN = 5'b11011
) (
    input  logic       clk4,
    input  logic       nrsthold,
    input  logic       tbl_we,
    input  logic [2:0] tbl_idx,
    input  logic [7:0] tbl_d,
    input  logic [7:0] ctx_in,
    input  logic       start,
    input  logic       bus_gnt,
    input  logic [7:0] ibus_in,
    output logic       bus_req,
    output logic [4:0] waddr,
    output logic [4:0] raddr,
    output logic [2:0] ir_out,
    output logic [7:0] ibus_out,
    output logic       ibus_oe,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [2:0] err_idx
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WCTX = 3'd2,
        S_WMB  = 3'd3,
        S_VFY  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t     r_state;
    logic [7:0] r_tbl [8];
    logic [2:0] r_idx;
    logic [4:0] r_waddr;
    logic [4:0] r_raddr;
    logic [7:0] r_data;
    logic       r_oe;
    logic       r_bus_req;
    logic       r_busy;
    logic       r_done;
    logic       r_err;
    logic [2:0] r_err_idx;

    logic [2:0] w_idx_nxt;
    logic       w_in_mb;

    assign w_idx_nxt = r_idx + 3'd1;
    assign w_in_mb   = (r_state == S_WMB) || (r_state == S_VFY);

    // The transaction fields are registered; a withdrawn grant turns the
    // current cycle into a stall by squashing them without touching state.
    assign waddr    = bus_gnt ? r_waddr : 5'd0;
    assign raddr    = bus_gnt ? r_raddr : 5'd0;
    assign ibus_oe  = bus_gnt & r_oe;
    assign ibus_out = (bus_gnt & r_oe) ? r_data : 8'h00;
    assign ir_out   = (bus_gnt & w_in_mb) ? r_idx : 3'd0;
    assign bus_req  = r_bus_req;
    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;
    assign err_idx  = r_err_idx;

    // Sequencer, shadow table and registered bus fields.
    always_ff @(posedge clk4 or negedge nrsthold) begin
        if (!nrsthold) begin
            r_state   <= S_IDLE;
            r_idx     <= 3'd0;
            r_waddr   <= 5'd0;
            r_raddr   <= 5'd0;
            r_data    <= 8'h00;
            r_oe      <= 1'b0;
            r_bus_req <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_err_idx <= 3'd0;
            for (int i = 0; i < 8; i++) begin
                r_tbl[i] <= 8'h00;
            end
        end else begin
            r_done <= 1'b0;

            // Table is frozen for the whole sequence.
            if (tbl_we && !r_busy) begin
                r_tbl[tbl_idx] <= tbl_d;
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state   <= S_REQ;
                        r_busy    <= 1'b1;
                        r_bus_req <= 1'b1;
                        r_err     <= 1'b0;
                        r_err_idx <= 3'd0;
                    end
                end
                S_REQ: begin
                    if (bus_gnt) begin
                        if (WRITE_CTX) begin
                            r_state <= S_WCTX;
                            r_waddr <= WADDR_CTX;
                            r_oe    <= 1'b1;
                            r_data  <= ctx_in;
                        end else begin
                            r_state <= S_WMB;
                            r_idx   <= 3'd0;
                            r_waddr <= WADDR_MBN;
                            r_oe    <= 1'b1;
                            r_data  <= r_tbl[0];
                        end
                    end
                end
                S_WCTX: begin
                    if (bus_gnt) begin
                        r_state <= S_WMB;
                        r_idx   <= 3'd0;
                        r_waddr <= WADDR_MBN;
                        r_oe    <= 1'b1;
                        r_data  <= r_tbl[0];
                    end
                end
                S_WMB: begin
                    if (bus_gnt) begin
                        if (r_idx == 3'd7) begin
                            r_idx   <= 3'd0;
                            r_waddr <= 5'd0;
                            r_oe    <= 1'b0;
                            r_data  <= 8'h00;
                            if (VERIFY) begin
                                r_state <= S_VFY;
                                r_raddr <= RADDR_MBN;
                            end else begin
                                r_state   <= S_DONE;
                                r_bus_req <= 1'b0;
                                r_done    <= 1'b1;
                            end
                        end else begin
                            r_idx  <= w_idx_nxt;
                            r_data <= r_tbl[w_idx_nxt];
                        end
                    end
                end
                S_VFY: begin
                    if (bus_gnt) begin
                        // Only the first mismatch is recorded.
                        if ((ibus_in != r_tbl[r_idx]) && !r_err) begin
                            r_err     <= 1'b1;
                            r_err_idx <= r_idx;
                        end
                        if (r_idx == 3'd7) begin
                            r_state   <= S_DONE;
                            r_idx     <= 3'd0;
                            r_raddr   <= 5'd0;
                            r_bus_req <= 1'b0;
                            r_done    <= 1'b1;
                        end else begin
                            r_idx <= w_idx_nxt;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mbu_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mbu_loader
//  Description : Directed self-checking bench for mbu_loader, with a simple
//                MBU echo model and a second instance built without CTX write
//                and without read-back.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mbu_loader;

    localparam logic [4:0] c_wmbn = 5'b11011;
    localparam logic [4:0] c_wctx = 5'b11110;
    localparam logic [4:0] c_rmbn = 5'b11011;

    logic       clk4 = 1'b0;
    logic       nrsthold = 1'b0;
    logic       tbl_we = 1'b0;
    logic [2:0] tbl_idx = 3'd0;
    logic [7:0] tbl_d = 8'h00;
    logic [7:0] ctx_in = 8'h00;
    logic       bus_gnt = 1'b1;
    logic       start_a = 1'b0;
    logic       start_b = 1'b0;
    logic [7:0] ibus_in_a;

    logic       bus_req_a, ibus_oe_a, busy_a, done_a, err_a;
    logic [4:0] waddr_a, raddr_a;
    logic [2:0] ir_out_a, err_idx_a;
    logic [7:0] ibus_out_a;

    logic       bus_req_b, ibus_oe_b, busy_b, done_b, err_b;
    logic [4:0] waddr_b, raddr_b;
    logic [2:0] ir_out_b, err_idx_b;
    logic [7:0] ibus_out_b;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int viol = 0;
    logic [7:0] mbu [8];
    logic [7:0] ctx_mem = 8'h00;
    logic [7:0] fault_mask = 8'h00;
    logic [7:0] wmb_seen [8];
    logic       prefill = 1'b0;
    logic       nv_raddr_seen = 1'b0;
    logic       nv_ctx_seen = 1'b0;

    always #5 clk4 = ~clk4;

    mbu_loader u_dut (
        .clk4(clk4), .nrsthold(nrsthold), .tbl_we(tbl_we), .tbl_idx(tbl_idx),
        .tbl_d(tbl_d), .ctx_in(ctx_in), .start(start_a), .bus_gnt(bus_gnt),
        .ibus_in(ibus_in_a), .bus_req(bus_req_a), .waddr(waddr_a),
        .raddr(raddr_a), .ir_out(ir_out_a), .ibus_out(ibus_out_a),
        .ibus_oe(ibus_oe_a), .busy(busy_a), .done(done_a), .err(err_a),
        .err_idx(err_idx_a)
    );

    mbu_loader #(.VERIFY(1'b0), .WRITE_CTX(1'b0)) u_dut_nv (
        .clk4(clk4), .nrsthold(nrsthold), .tbl_we(tbl_we), .tbl_idx(tbl_idx),
        .tbl_d(tbl_d), .ctx_in(ctx_in), .start(start_b), .bus_gnt(bus_gnt),
        .ibus_in(8'h00), .bus_req(bus_req_b), .waddr(waddr_b),
        .raddr(raddr_b), .ir_out(ir_out_b), .ibus_out(ibus_out_b),
        .ibus_oe(ibus_oe_b), .busy(busy_b), .done(done_b), .err(err_b),
        .err_idx(err_idx_b)
    );

    // MBU echo model: read returns what was written unless faulted.
    assign ibus_in_a = (raddr_a == c_rmbn) ?
                       (fault_mask[ir_out_a] ? 8'hFF : mbu[ir_out_a]) : 8'h00;

    // MBU model storage.
    always @(posedge clk4) begin
        if (prefill) begin
            for (int i = 0; i < 8; i++) mbu[i] <= 8'h5A;
            ctx_mem <= 8'h5A;
        end else begin
            if (ibus_oe_a && waddr_a == c_wmbn) mbu[ir_out_a] <= ibus_out_a;
            if (ibus_oe_a && waddr_a == c_wctx) ctx_mem <= ibus_out_a;
        end
    end

    // Bus-protocol invariants and activity monitors.
    always @(negedge clk4) begin
        if (nrsthold) begin
            if (ibus_oe_a && raddr_a != 5'd0) viol++;
            if (waddr_a != 5'd0 && raddr_a != 5'd0) viol++;
            if (raddr_b != 5'd0) nv_raddr_seen = 1'b1;
            if (waddr_b == c_wctx) nv_ctx_seen = 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk4);
        #1;
        cyc++;
    endtask

    task automatic load_tbl(input logic [7:0] base);
        for (int n = 0; n < 8; n++) begin
            tbl_we = 1'b1; tbl_idx = 3'(n); tbl_d = base + 8'(n);
            step();
        end
        tbl_we = 1'b0;
    endtask

    task automatic do_prefill();
        prefill = 1'b1;
        step();
        prefill = 1'b0;
    endtask

    // Runs one sequence on instance A (sel=0) or B (sel=1); returns the cycle
    // on which done is seen, counting the REQ cycle as 1.
    task automatic run_seq(input bit sel, input bit stall_en, input bit busy_we,
                           output int cycles);
        bit stalled = 1'b0;
        for (int i = 0; i < 8; i++) wmb_seen[i] = 8'hEE;
        cyc = 0;
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        step();
        start_a = 1'b0; start_b = 1'b0;
        if (busy_we) begin
            tbl_we = 1'b1; tbl_idx = 3'd6; tbl_d = 8'h11;
        end else begin
            tbl_we = 1'b0;
        end
        if (!sel) begin
            chk("busy_at_accept", busy_a, 1'b1);
            chk("err_clr_at_accept", err_a, 1'b0);
        end
        while (!(sel ? done_b : done_a) && cyc < 60) begin
            if (cyc >= 2) tbl_we = 1'b0;
            if (ibus_oe_a && waddr_a == c_wmbn) wmb_seen[ir_out_a] = ibus_out_a;
            if (stall_en && !stalled && waddr_a == c_wmbn && ir_out_a == 3'd4) begin
                stalled = 1'b1;
                bus_gnt = 1'b0;
                #1;
                chk("stall0", {waddr_a, raddr_a, ibus_oe_a}, 11'd0);
                step();
                chk("stall1", {waddr_a, raddr_a, ibus_oe_a}, 11'd0);
                step();
                chk("stall2", {waddr_a, raddr_a, ibus_oe_a}, 11'd0);
                step();
                bus_gnt = 1'b1;
                #1;
                chk("reissue_k4", {waddr_a, ir_out_a, ibus_oe_a, ibus_out_a},
                    {c_wmbn, 3'd4, 1'b1, 8'h84});
            end
            step();
        end
        tbl_we = 1'b0;
        if (cyc >= 60) chk("done_timeout", 1'b1, 1'b0);
        cycles = cyc;
        if (!sel) begin
            chk("done_cycle_busreq_busy", {bus_req_a, busy_a}, 2'b01);
            step();
            chk("after_done_done_busy", {done_a, busy_a}, 2'b00);
        end else begin
            step();
        end
    endtask

    initial begin
        int cycles;
        logic done_hit;

        // Reset state.
        step(); step();
        chk("reset_outs_a", {bus_req_a, waddr_a, raddr_a, ir_out_a, ibus_out_a,
            ibus_oe_a, busy_a, done_a, err_a, err_idx_a}, 38'd0);
        #2 nrsthold = 1'b1;
        step();

        // Reset in the middle of WMB k=3.
        load_tbl(8'h80);
        ctx_in = 8'h05;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        for (int i = 0; i < 20 && !(waddr_a == c_wmbn && ir_out_a == 3'd3); i++) step();
        chk("reached_wmb3", {waddr_a, ir_out_a, ibus_out_a}, {c_wmbn, 3'd3, 8'h83});
        nrsthold = 1'b0;
        #1;
        chk("midrun_reset_outs", {bus_req_a, waddr_a, raddr_a, ir_out_a, ibus_out_a,
            ibus_oe_a, busy_a, done_a, err_a, err_idx_a}, 38'd0);
        step();
        #1 nrsthold = 1'b1;
        done_hit = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (done_a) done_hit = 1'b1;
        end
        chk("no_done_after_reset", done_hit, 1'b0);
        do_prefill();
        run_seq(1'b0, 1'b0, 1'b0, cycles);
        chk("cleared_tbl_cycles", cycles, 19);
        for (int n = 0; n < 8; n++) chk($sformatf("cleared_tbl_wmb%0d", n), wmb_seen[n], 8'h00);
        chk("cleared_tbl_mbu3", mbu[3], 8'h00);
        chk("cleared_tbl_err", err_a, 1'b0);

        // Nominal run with echo.
        load_tbl(8'h80);
        do_prefill();
        run_seq(1'b0, 1'b0, 1'b0, cycles);
        chk("nominal_cycles", cycles, 19);
        chk("nominal_ctx", ctx_mem, 8'h05);
        for (int n = 0; n < 8; n++) chk($sformatf("nominal_mbu%0d", n), mbu[n], 8'h80 + 8'(n));
        chk("nominal_err", {err_a, err_idx_a}, 4'd0);

        // Read-back faults on k=2 and k=6.
        fault_mask = 8'b0100_0100;
        run_seq(1'b0, 1'b0, 1'b0, cycles);
        chk("fault_cycles", cycles, 19);
        chk("fault_err", {err_a, err_idx_a}, {1'b1, 3'd2});
        fault_mask = 8'h00;

        // Grant withdrawn for three cycles at WMB k=4.
        run_seq(1'b0, 1'b1, 1'b0, cycles);
        chk("stall_cycles", cycles, 22);
        chk("stall_mbu4", mbu[4], 8'h84);
        chk("stall_err", err_a, 1'b0);

        // Table write on the accepting edge is used; writes while busy are not.
        tbl_we = 1'b1; tbl_idx = 3'd5; tbl_d = 8'hAA;
        run_seq(1'b0, 1'b0, 1'b1, cycles);
        chk("tblwe_wmb5", wmb_seen[5], 8'hAA);
        chk("tblwe_wmb6", wmb_seen[6], 8'h86);
        chk("tblwe_mbu5", mbu[5], 8'hAA);
        chk("tblwe_err", err_a, 1'b0);

        // No read-back, no CTX write.
        nv_raddr_seen = 1'b0;
        nv_ctx_seen = 1'b0;
        run_seq(1'b1, 1'b0, 1'b0, cycles);
        chk("nv_cycles", cycles, 10);
        chk("nv_raddr", nv_raddr_seen, 1'b0);
        chk("nv_ctx", nv_ctx_seen, 1'b0);
        chk("nv_busy_after", busy_b, 1'b0);

        chk("bus_invariants", viol, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
